branch_target_table: RTL

Programmable, multi-program branch target table that replaces the hard-wired PC lookup in the fetch stage. Software, or a test harness, loads per-program entries at run time. Each entry holds either an absolute target or a PC-relative offset. The fetch stage issues indexed lookups through a valid/ready handshake and receives a registered target one cycle later. A built-in sweep FSM invalidates the whole table on command.

---
 rtl/branch_lut_pkg.sv | 20 ++
 rtl/lut_clear_ctrl.sv | 59 +++++
 rtl/branch_target_table.sv | 105 ++++++++++
 3 files changed

// File: rtl/branch_lut_pkg.sv
// Shared types and defaults for the fetch-stage branch target table.
// The ENTRIES/PROGS defaults are also used by the fetch stage.
package branch_lut_pkg;

   localparam int LUT_D       = 12;
   localparam int LUT_ENTRIES = 16;
   localparam int LUT_PROGS   = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   typedef struct packed {
      logic             valid;
      logic             rel;
      logic [LUT_D-1:0] data;
   } lut_entry_t;

endpackage

// File: rtl/lut_clear_ctrl.sv
// Clear sweep controller: invalidates table entries one per cycle, bank-major order.
//
// state | meaning
// IDLE  | table available for writes and lookups
// CLEAR | sweeping, one valid bit cleared per cycle
module lut_clear_ctrl
   import branch_lut_pkg::*;
#(
   parameter  int N  = 64,
   localparam int AW = $clog2(N)
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          clr_start,
   output logic          busy,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   localparam logic [AW-1:0] LAST = AW'(N - 1);

   clr_state_e    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The counter counts down the remaining sweep cycles; the address is its complement to LAST.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clr_we   = 1'b0;
      clr_addr = LAST - cnt_q;
      case (state_q)
         IDLE: begin
            if (clr_start) begin
               state_d = CLEAR;
               cnt_d   = LAST;
            end
         end
         CLEAR: begin
            clr_we = 1'b1;
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == CLEAR);

endmodule

// File: rtl/branch_target_table.sv
// Multi-bank branch target table with write-first bypass, registered lookup response
// and a sweep-based invalidate.
module branch_target_table
   import branch_lut_pkg::*;
#(
   parameter  int D       = LUT_D,
   parameter  int ENTRIES = LUT_ENTRIES,
   parameter  int PROGS   = LUT_PROGS,
   localparam int IW      = $clog2(ENTRIES),
   localparam int PW      = (PROGS > 1) ? $clog2(PROGS) : 1
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic [PW-1:0] prog_sel,
   input  logic          wr_en,
   input  logic [PW-1:0] wr_prog,
   input  logic [IW-1:0] wr_idx,
   input  logic          wr_rel,
   input  logic [D-1:0]  wr_data,
   input  logic          clr_start,
   output logic          busy,
   input  logic          lk_valid,
   output logic          lk_ready,
   input  logic [IW-1:0] lk_idx,
   input  logic [D-1:0]  lk_pc,
   output logic          tgt_valid,
   output logic [D-1:0]  tgt,
   output logic          tgt_miss
);

   localparam int N  = PROGS * ENTRIES;
   localparam int AW = $clog2(N);

   logic [N-1:0]  valid_q;
   logic          rel_q  [N];
   logic [D-1:0]  data_q [N];

   logic          clr_we;
   logic [AW-1:0] clr_addr;
   logic          wr_fire, lk_fire;
   logic [AW-1:0] wr_addr, lk_addr;
   lut_entry_t    rd_ent;
   logic [D-1:0]  tgt_d;

   lut_clear_ctrl #(.N(N)) u_clr (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .clr_start (clr_start),
      .busy      (busy),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr)
   );

   assign lk_ready = ~busy;
   // A clear request in the same cycle takes priority over the write.
   assign wr_fire  = wr_en & ~busy & ~clr_start;
   assign lk_fire  = lk_valid & lk_ready;
   assign wr_addr  = AW'({wr_prog, wr_idx});
   assign lk_addr  = AW'({prog_sel, lk_idx});

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         valid_q <= '0;
      end else begin
         if (clr_we)  valid_q[clr_addr] <= 1'b0;
         if (wr_fire) valid_q[wr_addr]  <= 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (wr_fire) begin
         rel_q[wr_addr]  <= wr_rel;
         data_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_ent.valid = valid_q[lk_addr];
      rd_ent.rel   = rel_q[lk_addr];
      rd_ent.data  = data_q[lk_addr];
      if (wr_fire && (wr_addr == lk_addr)) begin
         rd_ent.valid = 1'b1;
         rd_ent.rel   = wr_rel;
         rd_ent.data  = wr_data;
      end
      if (!rd_ent.valid)   tgt_d = '0;
      else if (rd_ent.rel) tgt_d = lk_pc + rd_ent.data;
      else                 tgt_d = rd_ent.data;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         tgt_valid <= 1'b0;
         tgt       <= '0;
         tgt_miss  <= 1'b0;
      end else begin
         tgt_valid <= lk_fire;
         if (lk_fire) begin
            tgt      <= tgt_d;
            tgt_miss <= ~rd_ent.valid;
         end
      end
   end

endmodule
